rs232_receiver: RTL and testbench

- Serial UART receiver for RS232 at 9600 or 115200 bps, 8 data bits, no parity, 1 stop bit, 25 MHz clock.
- Counterpart of the team's RS232 transmitter: same bit-period constants, same `fsel` meaning, same ready semantics.
- Synchronises `RxD`, validates the start bit at mid-bit, samples each bit at its centre, and holds the byte with status flags until the consumer acknowledges it.
- Sits between the board RxD pin and the I/O register file; software polls `rdy` and pulses `done` after reading `data`.

---
 rtl/rs232_pkg.sv | 19 +
 rtl/sync2.sv | 25 ++
 rtl/rs232_receiver.sv | 149 ++++++++++++++
 tb/tb_rs232_receiver.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared RS232 constants and receiver state encoding.
// The transmitter takes its bit periods from here too, so both ends always agree.
package rs232_pkg;

  localparam int unsigned TickW = 12;

  localparam logic [TickW-1:0] LIMIT_FAST = 12'd217;   // 115200 bps at 25 MHz
  localparam logic [TickW-1:0] LIMIT_SLOW = 12'd2604;  // 9600 bps at 25 MHz
  localparam logic [TickW-1:0] HALF_FAST  = 12'd108;
  localparam logic [TickW-1:0] HALF_SLOW  = 12'd1302;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous level input.
// Resets to 1, which is the idle level of a UART line.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rs232_receiver.sv
// 8N1 UART receiver at 9600 or 115200 bps from a 25 MHz clock.
// Centre-samples each bit and holds the byte with status flags until acknowledged.
module rs232_receiver
  import rs232_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  input  logic       fsel,
  input  logic       done,
  output logic [7:0] data,
  output logic       rdy,
  output logic       ferr,
  output logic       ovr
);

  logic             rxs;
  logic             rxs_dly_q;
  logic [1:0]       flush_q, flush_d;
  logic             line_ok;
  rx_state_e        state_q, state_d;
  logic [TickW-1:0] tick_q, tick_d, tick_inc;
  logic [TickW-1:0] lim_q, lim_d;
  logic [TickW-1:0] half_q, half_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       data_q, data_d;
  logic             rdy_q, rdy_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (RxD),
    .q   (rxs)
  );

  // After reset the synchroniser still shows its reset value of 1 for two cycles. Edge
  // detection stays off until both rxs and its delayed copy reflect the real line, so a
  // line held low through reset is not taken as a start bit.
  assign line_ok  = (flush_q == 2'd3);
  assign flush_d  = line_ok ? flush_q : flush_q + 2'd1;

  // tick_q holds the cycles elapsed since the last reference point, minus one.
  assign tick_inc = tick_q + 12'd1;

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    lim_d    = lim_q;
    half_d   = half_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    rdy_d    = rdy_q;
    ferr_d   = ferr_q;
    ovr_d    = ovr_q;

    if (done) begin
      rdy_d  = 1'b0;
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (line_ok && rxs_dly_q && !rxs) begin
          lim_d   = fsel ? LIMIT_FAST : LIMIT_SLOW;
          half_d  = fsel ? HALF_FAST : HALF_SLOW;
          tick_d  = '0;
          state_d = START;
        end
      end
      START: begin
        tick_d = tick_inc;
        if (tick_inc == half_q) begin
          if (!rxs) begin
            tick_d   = '0;
            bitcnt_d = '0;
            state_d  = DATA;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      DATA: begin
        tick_d = tick_inc;
        if (tick_inc == lim_q) begin
          shreg_d  = {rxs, shreg_q[7:1]};
          tick_d   = '0;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        tick_d = tick_inc;
        if (tick_inc == lim_q) begin
          data_d  = shreg_q;
          rdy_d   = 1'b1;
          ferr_d  = ~rxs;
          // A same-cycle acknowledge consumed the old byte, so nothing was overwritten.
          ovr_d   = rdy_q & ~done;
          tick_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxs_dly_q <= 1'b1;
      flush_q   <= 2'd0;
      state_q   <= IDLE;
      tick_q    <= '0;
      lim_q     <= LIMIT_FAST;
      half_q    <= HALF_FAST;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rxs_dly_q <= rxs;
      flush_q   <= flush_d;
      state_q   <= state_d;
      tick_q    <= tick_d;
      lim_q     <= lim_d;
      half_q    <= half_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data = data_q;
  assign rdy  = rdy_q;
  assign ferr = ferr_q;
  assign ovr  = ovr_q;

endmodule

// File: tb/tb_rs232_receiver.sv
// Scoreboard bench for rs232_receiver: frame senders queue the expected byte, flags and
// arrival cycle; a monitor pops and compares whenever a new byte is presented.
module tb_rs232_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       RxD;
  logic       fsel;
  logic       done;
  logic [7:0] data;
  logic       rdy;
  logic       ferr;
  logic       ovr;

  typedef struct {
    logic [7:0]  data;
    logic        ferr;
    logic        ovr;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned s2;

  rs232_receiver dut (
    .clk  (clk),
    .rst  (rst),
    .RxD  (RxD),
    .fsel (fsel),
    .done (done),
    .data (data),
    .rdy  (rdy),
    .ferr (ferr),
    .ovr  (ovr)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  // Monitor: a new byte is a rising rdy, or a data change while rdy stays high.
  logic       rdy_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rdy && (!rdy_prev || data !== data_prev)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_byte: got data 0x%0h at cycle %0d, expected no byte", data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", data, e.data);
        check("rx_ferr", ferr, e.ferr);
        check("rx_ovr", ovr, e.ovr);
        check("rx_cycle", cyc, e.cyc);
      end
    end
    rdy_prev  <= rdy;
    data_prev <= data;
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called 1 time unit after a clock edge; the start bit begins at that edge.
  task automatic send_byte(input logic [7:0] b, input logic stop, input logic fast,
                           input logic exp_ovr);
    int unsigned lim;
    int unsigned lat;
    lim = fast ? 217 : 2604;
    lat = fast ? 2064 : 24741;  // 3 cycles to D, then D + half + 9*lim + 1
    exp_q.push_back(exp_t'{data: b, ferr: ~stop, ovr: exp_ovr, cyc: cyc + lat});
    RxD = 1'b0;
    cycles(lim);
    for (int k = 0; k < 8; k++) begin
      RxD = b[k];
      cycles(lim);
    end
    RxD = stop;
    cycles(lim);
  endtask

  task automatic pulse_done(input string name);
    done = 1'b1;
    cycles(1);
    done = 1'b0;
    check({name, "_rdy_cleared"}, rdy, 0);
    check({name, "_ferr_cleared"}, ferr, 0);
    check({name, "_ovr_cleared"}, ovr, 0);
  endtask

  initial begin
    rst  = 1'b1;
    RxD  = 1'b1;
    fsel = 1'b1;
    done = 1'b0;
    cycles(5);
    check("reset_data", data, 0);
    check("reset_rdy", rdy, 0);
    check("reset_ferr", ferr, 0);
    check("reset_ovr", ovr, 0);
    rst = 1'b0;
    cycles(10);

    // Fast 0xA5
    send_byte(8'hA5, 1'b1, 1'b1, 1'b0);
    cycles(20);
    check("a5_delivered", exp_q.size(), 0);
    check("a5_rdy_held", rdy, 1);
    pulse_done("a5");

    // Slow 0x3C with fsel toggled mid-frame
    fsel = 1'b0;
    fork
      send_byte(8'h3C, 1'b1, 1'b0, 1'b0);
      begin
        cycles(10000);
        fsel = 1'b1;
      end
    join
    cycles(20);
    check("3c_delivered", exp_q.size(), 0);
    pulse_done("3c");

    // 50-cycle glitch, then a valid frame
    RxD = 1'b0;
    cycles(50);
    RxD = 1'b1;
    cycles(300);
    check("glitch_no_rdy", rdy, 0);
    send_byte(8'h5A, 1'b1, 1'b1, 1'b0);
    cycles(20);
    check("5a_delivered", exp_q.size(), 0);
    pulse_done("5a");

    // Framing error
    send_byte(8'h55, 1'b0, 1'b1, 1'b0);
    RxD = 1'b1;
    cycles(20);
    check("55_delivered", exp_q.size(), 0);
    check("55_ferr_held", ferr, 1);
    pulse_done("55");

    // Back-to-back without acknowledge: overrun
    send_byte(8'h11, 1'b1, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b1, 1'b1);
    cycles(20);
    check("ovr_delivered", exp_q.size(), 0);
    check("ovr_flag_held", ovr, 1);
    pulse_done("ovr");

    // Back-to-back with done in the exact completion cycle of the second frame
    send_byte(8'h11, 1'b1, 1'b1, 1'b0);
    s2 = cyc;
    fork
      send_byte(8'h22, 1'b1, 1'b1, 1'b0);
      begin
        cycles(2063);
        done = 1'b1;
        cycles(1);
        done = 1'b0;
      end
    join
    cycles(20);
    check("coll_delivered", exp_q.size(), 0);
    check("coll_rdy", rdy, 1);
    check("coll_ovr", ovr, 0);
    check("coll_data", data, 8'h22);
    pulse_done("coll");

    // Reset during data bit 4 with the line held low
    RxD = 1'b0;
    cycles(217 * 5 + 100);
    rst = 1'b1;
    cycles(5);
    rst = 1'b0;
    cycles(1);
    check("midrst_data", data, 0);
    check("midrst_rdy", rdy, 0);
    check("midrst_ferr", ferr, 0);
    check("midrst_ovr", ovr, 0);
    cycles(3000);
    check("midrst_no_byte", rdy, 0);
    RxD = 1'b1;
    cycles(50);
    send_byte(8'hF0, 1'b1, 1'b1, 1'b0);
    cycles(20);
    check("f0_delivered", exp_q.size(), 0);
    pulse_done("f0");

    cycles(10);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
